// File: rtl/lut_neuron_rw_if.sv
// Bundle of the configuration port and the lookup valid/ready stream of one
// LUT neuron. The master drives requests; the slave (the neuron) answers.
interface lut_neuron_rw_if #(
    parameter int IN_W  = 6,
    parameter int OUT_W = 1
);
    logic             cfg_clear;
    logic             cfg_we;
    logic [IN_W-1:0]  cfg_addr;
    logic [OUT_W-1:0] cfg_data;
    logic             cfg_busy;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;

    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    modport master (
        output cfg_clear, cfg_we, cfg_addr, cfg_data, in_valid, in_data, out_ready,
        input  cfg_busy, in_ready, out_valid, out_data
    );

    modport slave (
        input  cfg_clear, cfg_we, cfg_addr, cfg_data, in_valid, in_data, out_ready,
        output cfg_busy, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/lut_neuron_rw.sv
// Runtime-reloadable LUT neuron: a register-based truth table cleared by an
// init sweep after reset or cfg_clear, rewritable through the config port,
// and read through a one-stage valid/ready pipeline.
module lut_neuron_rw #(
    parameter int               IN_W     = 6,
    parameter int               OUT_W    = 1,
    parameter logic [OUT_W-1:0] INIT_VAL = '0
) (
    input logic            clk,
    input logic            rst_n,
    lut_neuron_rw_if.slave bus
);
    localparam int DEPTH = 2 ** IN_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t           state, state_next;
    logic [IN_W-1:0]  count, count_next;
    logic [OUT_W-1:0] table_q [DEPTH];

    logic             out_valid_q;
    logic [OUT_W-1:0] out_data_q;

    logic             in_ready_c;
    logic             accept;
    logic             table_we;
    logic [IN_W-1:0]  table_addr;
    logic [OUT_W-1:0] table_wdata;

    // Lookup handshake: a request is taken only in RUN, never alongside a clear,
    // and only when the output stage is empty or draining this cycle.
    always_comb begin
        in_ready_c = (state == RUN) && !bus.cfg_clear && (!out_valid_q || bus.out_ready);
        accept     = bus.in_valid && in_ready_c;
    end

    // State and sweep counter register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Next state, sweep counter and the single table write port.
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would infer a latch.
    always_comb begin
        state_next  = state;
        count_next  = count;
        table_we    = 1'b0;
        table_addr  = bus.cfg_addr;
        table_wdata = bus.cfg_data;
        case (state)
            INIT: begin
                // Sweep owns the write port; config writes are dropped.
                table_we    = 1'b1;
                table_addr  = count;
                table_wdata = INIT_VAL;
                if (bus.cfg_clear) begin
                    count_next = '0;
                end else if (count == IN_W'(DEPTH - 1)) begin
                    state_next = RUN;
                    count_next = '0;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            RUN: begin
                if (bus.cfg_clear) begin
                    state_next = INIT;
                    count_next = '0;
                end else if (bus.cfg_we) begin
                    table_we = 1'b1;
                end
            end
            default: state_next = INIT;
        endcase
    end

    // Truth table storage.
    // NOTE: the table has no reset; its contents are defined by the init sweep,
    // so a reset network across every entry would buy nothing.
    always_ff @(posedge clk) begin
        if (table_we) begin
            table_q[table_addr] <= table_wdata;
        end
    end

    // Output stage: the lookup reads the pre-edge table, so a same-edge config
    // write to the looked-up entry is seen only by later lookups.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (state == INIT || bus.cfg_clear) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= table_q[bus.in_data];
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.cfg_busy  = (state == INIT);
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
endmodule
